// File: rtl/pe_dot_sequencer.sv
// Sequences one unsigned dot product of length len through a registered-multiplier PE.
// Result appears len+3 cycles after start (1 cycle for len=0); held until res_ready; optional PE_DOT_ACC_SAT_EN saturates.
module pe_dot_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_W      = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic [ADDR_W-1:0]       w_base,
    input  logic [ADDR_W-1:0]       x_base,
    output logic                    busy,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       w_addr,
    output logic [ADDR_W-1:0]       x_addr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH-1:0]   x_data,
    output logic [DATA_WIDTH-1:0]   pe_w,
    output logic [DATA_WIDTH-1:0]   pe_x,
    input  logic [2*DATA_WIDTH-1:0] pe_y,
    output logic [ACC_WIDTH-1:0]    res_data,
`ifdef PE_DOT_ACC_SAT_EN
    output logic                    res_ovf,
`endif
    output logic                    res_valid,
    input  logic                    res_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t               state;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     idx;
    logic                 v1;
    logic                 v2;
    logic [ACC_WIDTH-1:0] acc;

    assign pe_w     = w_data;
    assign pe_x     = x_data;
    assign busy     = (state != IDLE);
    assign res_data = acc;

`ifdef PE_DOT_ACC_SAT_EN
    logic               ovf;
    logic [ACC_WIDTH:0] sum;
    assign sum     = {1'b0, acc} + {1'b0, ACC_WIDTH'(pe_y)};
    assign res_ovf = ovf;
`else
    logic [ACC_WIDTH-1:0] sum;
    assign sum = acc + ACC_WIDTH'(pe_y);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            w_addr    <= '0;
            x_addr    <= '0;
            res_valid <= 1'b0;
            len_r     <= '0;
            idx       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            acc       <= '0;
`ifdef PE_DOT_ACC_SAT_EN
            ovf       <= 1'b0;
`endif
        end else begin
            v1 <= rd_en;
            v2 <= v1;
            if (v2) begin
`ifdef PE_DOT_ACC_SAT_EN
                if (sum[ACC_WIDTH]) begin
                    acc <= '1;
                    ovf <= 1'b1;
                end else begin
                    acc <= sum[ACC_WIDTH-1:0];
                end
`else
                acc <= sum;
`endif
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_r  <= len;
                        idx    <= '0;
                        acc    <= '0;
`ifdef PE_DOT_ACC_SAT_EN
                        ovf    <= 1'b0;
`endif
                        w_addr <= w_base;
                        x_addr <= x_base;
                        if (len == '0) begin
                            state     <= OUT;
                            res_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                            rd_en <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // idx is the element whose read is on the bus this cycle
                    if (idx == len_r - LEN_W'(1)) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        idx    <= idx + LEN_W'(1);
                        w_addr <= w_addr + ADDR_W'(1);
                        x_addr <= x_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // the last product lands in acc on the same edge v2 drops
                    if (!v1) begin
                        state     <= OUT;
                        res_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Drives a 32-bit/16-bit-address instance and a 16-bit/4-bit-address instance with shared jobs.
// Buffers and the PE are modelled behaviourally; expected results are hand-computed.
module tb_pe_dot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, res_ready;
    logic [15:0] len, w_base, x_base;

    logic        b_busy, b_rd_en, b_res_valid;
    logic [15:0] b_w_addr, b_x_addr;
    logic [7:0]  b_w_data, b_x_data, b_pe_w, b_pe_x;
    logic [15:0] b_pe_y;
    logic [31:0] b_res_data;

    logic        s_busy, s_rd_en, s_res_valid;
    logic [3:0]  s_w_addr, s_x_addr;
    logic [7:0]  s_w_data, s_x_data, s_pe_w, s_pe_x;
    logic [15:0] s_pe_y;
    logic [15:0] s_res_data;
`ifdef PE_DOT_ACC_SAT_EN
    logic        b_ovf, s_ovf;
`endif

    logic [7:0] w_mem [16];
    logic [7:0] x_mem [16];

    int checks   = 0;
    int failures = 0;

    pe_dot_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LEN_W(16), .ADDR_W(16)) u_big (
        .clk(clk), .rst(rst), .start(start), .len(len), .w_base(w_base), .x_base(x_base),
        .busy(b_busy), .rd_en(b_rd_en), .w_addr(b_w_addr), .x_addr(b_x_addr),
        .w_data(b_w_data), .x_data(b_x_data), .pe_w(b_pe_w), .pe_x(b_pe_x), .pe_y(b_pe_y),
        .res_data(b_res_data),
`ifdef PE_DOT_ACC_SAT_EN
        .res_ovf(b_ovf),
`endif
        .res_valid(b_res_valid), .res_ready(res_ready)
    );

    pe_dot_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_W(16), .ADDR_W(4)) u_small (
        .clk(clk), .rst(rst), .start(start), .len(len), .w_base(w_base[3:0]), .x_base(x_base[3:0]),
        .busy(s_busy), .rd_en(s_rd_en), .w_addr(s_w_addr), .x_addr(s_x_addr),
        .w_data(s_w_data), .x_data(s_x_data), .pe_w(s_pe_w), .pe_x(s_pe_x), .pe_y(s_pe_y),
        .res_data(s_res_data),
`ifdef PE_DOT_ACC_SAT_EN
        .res_ovf(s_ovf),
`endif
        .res_valid(s_res_valid), .res_ready(res_ready)
    );

    // Buffers index on the low address nibble so both instances see identical data.
    always @(posedge clk) begin
        b_w_data <= w_mem[b_w_addr[3:0]];
        b_x_data <= x_mem[b_x_addr[3:0]];
        s_w_data <= w_mem[s_w_addr];
        s_x_data <= x_mem[s_x_addr];
        b_pe_y   <= b_pe_w * b_pe_x;
        s_pe_y   <= s_pe_w * s_pe_x;
    end

    typedef struct {
        int     len;
        int     wb;
        int     xb;
        int     hold;
        int     poke;
        longint eb;
        longint esw;
        longint ess;
        int     eov;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, longint'({b_busy, b_rd_en, b_res_valid, s_busy, s_rd_en, s_res_valid}), 0);
        chk({tag, "_big_bus"}, longint'(b_w_addr) + longint'(b_x_addr) + longint'(b_res_data), 0);
        chk({tag, "_small_bus"}, longint'(s_w_addr) + longint'(s_x_addr) + longint'(s_res_data), 0);
`ifdef PE_DOT_ACC_SAT_EN
        chk({tag, "_ovf"}, longint'({b_ovf, s_ovf}), 0);
`endif
    endtask

    task automatic run_job(input int j);
        vec_t        v;
        int          rd_b, rd_s, first_rd, vcyc, xfer, bad_addr, unstable, idle_bad;
        logic [31:0] held_b;
        logic [15:0] held_s;
        logic        held_bo, held_so;
        v = tbl[j];
        rd_b = 0; rd_s = 0; first_rd = -1; vcyc = -1; xfer = -1;
        bad_addr = 0; unstable = 0; idle_bad = 0;
        held_b = '0; held_s = '0; held_bo = 1'b0; held_so = 1'b0;
        @(negedge clk);
        len = 16'(v.len); w_base = 16'(v.wb); x_base = 16'(v.xb);
        start = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 100 && xfer < 0; cyc++) begin
            if (b_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (b_w_addr != 16'(v.wb + rd_b) || b_x_addr != 16'(v.xb + rd_b)) bad_addr++;
                rd_b++;
            end
            if (s_rd_en) begin
                if (s_w_addr != 4'(v.wb + rd_s) || s_x_addr != 4'(v.xb + rd_s)) bad_addr++;
                rd_s++;
            end
            if (s_res_valid != b_res_valid) unstable++;
            if (b_res_valid) begin
                if (vcyc < 0) begin
                    vcyc   = cyc;
                    held_b = b_res_data;
                    held_s = s_res_data;
`ifdef PE_DOT_ACC_SAT_EN
                    held_bo = b_ovf;
                    held_so = s_ovf;
`endif
                end else if (b_res_data != held_b || s_res_data != held_s) begin
                    unstable++;
                end
            end else if (vcyc >= 0) begin
                unstable++;
            end
            start     = (v.poke != 0 && cyc == v.poke);
            res_ready = (vcyc >= 0 && cyc >= vcyc + v.hold);
            if (b_res_valid && res_ready) xfer = cyc;
            @(negedge clk);
        end
        start = 1'b0;
        res_ready = 1'b0;
        chk($sformatf("j%0d_first_rd", j), first_rd, (v.len == 0) ? -1 : 1);
        chk($sformatf("j%0d_rd_cnt_big", j), rd_b, v.len);
        chk($sformatf("j%0d_rd_cnt_small", j), rd_s, v.len);
        chk($sformatf("j%0d_bad_addr", j), bad_addr, 0);
        chk($sformatf("j%0d_valid_cycle", j), vcyc, (v.len == 0) ? 1 : v.len + 3);
        chk($sformatf("j%0d_xfer_cycle", j), xfer, (v.len == 0 ? 1 : v.len + 3) + v.hold);
        chk($sformatf("j%0d_res_big", j), longint'(held_b), v.eb);
`ifdef PE_DOT_ACC_SAT_EN
        chk($sformatf("j%0d_res_small", j), longint'(held_s), v.ess);
        chk($sformatf("j%0d_ovf", j), longint'({held_bo, held_so}), longint'(v.eov));
`else
        chk($sformatf("j%0d_res_small", j), longint'(held_s), v.esw);
`endif
        chk($sformatf("j%0d_unstable", j), unstable, 0);
        chk($sformatf("j%0d_after_xfer", j), longint'({b_busy, b_res_valid, s_busy, s_res_valid}), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (b_busy || s_busy || b_res_valid || b_rd_en) idle_bad++;
        end
        chk($sformatf("j%0d_stays_idle", j), idle_bad, 0);
    endtask

    initial begin
        int quiet_bad;
        for (int i = 0; i < 16; i++) begin
            w_mem[i] = 8'd0;
            x_mem[i] = 8'd0;
        end
        w_mem[0] = 8'd1; w_mem[1] = 8'd2; w_mem[2] = 8'd3; w_mem[3] = 8'd4;
        x_mem[0] = 8'd5; x_mem[1] = 8'd6; x_mem[2] = 8'd7; x_mem[3] = 8'd8;
        w_mem[4] = 8'd255; w_mem[5] = 8'd255;
        x_mem[4] = 8'd255; x_mem[5] = 8'd255;
        w_mem[14] = 8'd2; w_mem[15] = 8'd3;
        x_mem[14] = 8'd1; x_mem[15] = 8'd1;
        w_mem[8] = 8'd3; x_mem[8] = 8'd4;

        //            len wb      xb       hold poke big     s_wrap s_sat  ovf
        tbl[0] = '{4, 0,      'h1230, 0,   0,   70,     70,    70,    0};
        tbl[1] = '{0, 0,      0,      0,   0,   0,      0,     0,     0};
        tbl[2] = '{2, 4,      4,      5,   0,   130050, 64514, 65535, 1};
        tbl[3] = '{3, 14,     14,     0,   0,   10,     10,    10,    0};
        tbl[4] = '{4, 0,      0,      0,   2,   70,     70,    70,    0};
        tbl[5] = '{1, 8,      8,      0,   0,   12,     12,    12,    0};

        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        len = '0; w_base = '0; x_base = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int j = 0; j < 5; j++) run_job(j);

        // Abandon a len=8 job with reset in its cycle 2.
        @(negedge clk);
        len = 16'd8; w_base = 16'd0; x_base = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b0;
        quiet_bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (b_res_valid || s_res_valid || b_rd_en || s_rd_en || b_busy) quiet_bad++;
        end
        chk("abandoned_quiet", quiet_bad, 0);

        run_job(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
